// File: rtl/stdcell_vector_checker.sv
// Wishbone-controlled exhaustive vector checker for small standard cells.
// Walks every input combination of the selected cell and counts response mismatches.
module stdcell_vector_checker #(
    parameter int SETTLE = 2,
    parameter int ERRW   = 16
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic [3:0]  stim_o,
    input  logic        resp_i,
    output logic        busy_o,
    output logic        irq_o
);

    typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_SETTLE, S_SAMPLE} state_t;

    localparam logic [3:0] SETTLE_LAST = 4'((SETTLE > 0) ? SETTLE - 1 : 0);

    state_t            state_q, state_d;
    logic [3:0]        sel_q, sel_d;
    logic [7:0]        passes_q, passes_d;
    logic [7:0]        pass_q, pass_d;
    logic [3:0]        vec_q, vec_d;
    logic [3:0]        settle_q, settle_d;
    logic [3:0]        stim_q, stim_d;
    logic              done_q, done_d;
    logic              fail_q, fail_d;
    logic              bad_sel_q, bad_sel_d;
    logic [ERRW-1:0]   errcnt_q, errcnt_d;
    logic [3:0]        ff_vec_q, ff_vec_d;
    logic              ff_valid_q, ff_valid_d;
    logic              irq_q, irq_d;
    logic              ack_q, ack_d;
    logic [31:0]       dat_q, dat_d;

    // Expected Y of the selected cell for input vector v (A=v[0] .. D=v[3]).
    function automatic logic expected_y(input logic [3:0] s, input logic [3:0] v);
        logic a, b, c, d;
        {d, c, b, a} = v;
        case (s)
            4'd0:    expected_y = a & b;
            4'd1:    expected_y = ~((a & b) | c);
            4'd2:    expected_y = ~((a & b) | (c & d));
            4'd3:    expected_y = a;
            4'd4:    expected_y = ~a;
            4'd5:    expected_y = c ? b : a;
            4'd6:    expected_y = ~(a & b);
            4'd7:    expected_y = ~(a & b & c);
            4'd8:    expected_y = a | b;
            4'd9:    expected_y = ~(a ^ b);
            4'd10:   expected_y = a ^ b;
            default: expected_y = 1'b0;
        endcase
    endfunction

    // Highest vector index for the cell; equals the mask of its used inputs.
    function automatic logic [3:0] last_vec(input logic [3:0] s);
        case (s)
            4'd3, 4'd4:       last_vec = 4'b0001;
            4'd1, 4'd5, 4'd7: last_vec = 4'b0111;
            4'd2:             last_vec = 4'b1111;
            default:          last_vec = 4'b0011;
        endcase
    endfunction

    logic       access, wr, rd, ctrl_wr;
    logic [7:0] passes_eff;

    assign access     = wbs_stb_i & wbs_cyc_i & ~ack_q;
    assign wr         = access & wbs_we_i;
    assign rd         = access & ~wbs_we_i;
    assign ctrl_wr    = wr & (wbs_adr_i[3:2] == 2'd0);
    assign passes_eff = (passes_q == 8'd0) ? 8'd1 : passes_q;

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        passes_d   = passes_q;
        pass_d     = pass_q;
        vec_d      = vec_q;
        settle_d   = settle_q;
        stim_d     = stim_q;
        done_d     = done_q;
        fail_d     = fail_q;
        bad_sel_d  = bad_sel_q;
        errcnt_d   = errcnt_q;
        ff_vec_d   = ff_vec_q;
        ff_valid_d = ff_valid_q;
        irq_d      = 1'b0;
        ack_d      = wbs_stb_i & wbs_cyc_i & ~ack_q;
        dat_d      = 32'd0;

        if (rd) begin
            case (wbs_adr_i[3:2])
                2'd0: dat_d = {16'd0, passes_q, sel_q, 4'd0};
                2'd1: dat_d = {28'd0, bad_sel_q, fail_q, done_q, state_q != S_IDLE};
                2'd2: dat_d = 32'(errcnt_q);
                default: dat_d = {23'd0, ff_valid_q, 4'd0, ff_vec_q};
            endcase
        end

        case (state_q)
            S_IDLE: begin
                if (ctrl_wr) begin
                    sel_d    = wbs_dat_i[7:4];
                    passes_d = wbs_dat_i[15:8];
                    if (wbs_dat_i[0] && !wbs_dat_i[1]) begin
                        done_d     = 1'b0;
                        fail_d     = 1'b0;
                        bad_sel_d  = 1'b0;
                        errcnt_d   = '0;
                        ff_vec_d   = 4'd0;
                        ff_valid_d = 1'b0;
                        if (wbs_dat_i[7:4] > 4'd10) begin
                            bad_sel_d = 1'b1;
                            done_d    = 1'b1;
                            irq_d     = 1'b1;
                        end else begin
                            state_d = S_DRIVE;
                            vec_d   = 4'd0;
                            pass_d  = 8'd0;
                            stim_d  = 4'd0;
                        end
                    end
                end
            end
            S_DRIVE: begin
                settle_d = 4'd0;
                state_d  = (SETTLE == 0) ? S_SAMPLE : S_SETTLE;
            end
            S_SETTLE: begin
                if (settle_q == SETTLE_LAST) begin
                    state_d = S_SAMPLE;
                end else begin
                    settle_d = settle_q + 4'd1;
                end
            end
            S_SAMPLE: begin
                if (resp_i != expected_y(sel_q, vec_q)) begin
                    fail_d = 1'b1;
                    if (errcnt_q != '1) errcnt_d = errcnt_q + 1'b1;
                    if (!ff_valid_q) begin
                        ff_vec_d   = vec_q;
                        ff_valid_d = 1'b1;
                    end
                end
                if (vec_q == last_vec(sel_q)) begin
                    if (pass_q == passes_eff - 8'd1) begin
                        state_d = S_IDLE;
                        stim_d  = 4'd0;
                        done_d  = 1'b1;
                        irq_d   = 1'b1;
                    end else begin
                        state_d = S_DRIVE;
                        pass_d  = pass_q + 8'd1;
                        vec_d   = 4'd0;
                        stim_d  = 4'd0;
                    end
                end else begin
                    state_d = S_DRIVE;
                    vec_d   = vec_q + 4'd1;
                    stim_d  = vec_q + 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Abort beats start and any completion landing in the same cycle.
        if (state_q != S_IDLE && ctrl_wr && wbs_dat_i[1]) begin
            state_d = S_IDLE;
            stim_d  = 4'd0;
            done_d  = done_q;
            irq_d   = 1'b0;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q    <= S_IDLE;
            sel_q      <= 4'd0;
            passes_q   <= 8'd0;
            pass_q     <= 8'd0;
            vec_q      <= 4'd0;
            settle_q   <= 4'd0;
            stim_q     <= 4'd0;
            done_q     <= 1'b0;
            fail_q     <= 1'b0;
            bad_sel_q  <= 1'b0;
            errcnt_q   <= '0;
            ff_vec_q   <= 4'd0;
            ff_valid_q <= 1'b0;
            irq_q      <= 1'b0;
            ack_q      <= 1'b0;
            dat_q      <= 32'd0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            passes_q   <= passes_d;
            pass_q     <= pass_d;
            vec_q      <= vec_d;
            settle_q   <= settle_d;
            stim_q     <= stim_d;
            done_q     <= done_d;
            fail_q     <= fail_d;
            bad_sel_q  <= bad_sel_d;
            errcnt_q   <= errcnt_d;
            ff_vec_q   <= ff_vec_d;
            ff_valid_q <= ff_valid_d;
            irq_q      <= irq_d;
            ack_q      <= ack_d;
            dat_q      <= dat_d;
        end
    end

    assign stim_o    = stim_q;
    assign busy_o    = (state_q != S_IDLE);
    assign irq_o     = irq_q;
    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;

endmodule

// File: tb/tb_stdcell_vector_checker.sv
// Directed bench for stdcell_vector_checker: the cell under test is modelled
// here and can respond correctly, stuck at 0, or inverted.
module tb_stdcell_vector_checker;

    logic        wb_clk_i;
    logic        wb_rst_ni;
    logic        wbs_stb_i, wbs_cyc_i, wbs_we_i;
    logic [31:0] wbs_adr_i, wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic [3:0]  stim_o;
    logic        resp_i;
    logic        busy_o, irq_o;

    int checks = 0;
    int errors = 0;

    logic [3:0] cur_sel;
    int         resp_mode;    // 0 correct, 1 stuck at 0, 2 inverted
    logic [3:0] stim_log [0:255];

    stdcell_vector_checker #(.SETTLE(2), .ERRW(16)) dut (
        .wb_clk_i  (wb_clk_i),
        .wb_rst_ni (wb_rst_ni),
        .wbs_stb_i (wbs_stb_i),
        .wbs_cyc_i (wbs_cyc_i),
        .wbs_we_i  (wbs_we_i),
        .wbs_adr_i (wbs_adr_i),
        .wbs_dat_i (wbs_dat_i),
        .wbs_ack_o (wbs_ack_o),
        .wbs_dat_o (wbs_dat_o),
        .stim_o    (stim_o),
        .resp_i    (resp_i),
        .busy_o    (busy_o),
        .irq_o     (irq_o)
    );

    initial wb_clk_i = 1'b0;
    always #5 wb_clk_i = ~wb_clk_i;

    function automatic logic cell_y(input logic [3:0] s, input logic [3:0] v);
        case (s)
            4'd0:    cell_y = v[0] & v[1];
            4'd2:    cell_y = !((v[0] && v[1]) || (v[2] && v[3]));
            4'd4:    cell_y = !v[0];
            4'd7:    cell_y = !(v[0] && v[1] && v[2]);
            default: cell_y = 1'b0;
        endcase
    endfunction

    assign resp_i = (resp_mode == 1) ? 1'b0 :
                    (resp_mode == 2) ? ~cell_y(cur_sel, stim_o) : cell_y(cur_sel, stim_o);

    task automatic wb_write(input logic [31:0] adr, input logic [31:0] dat);
        if (wbs_ack_o) @(negedge wb_clk_i);
        wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = 1'b1;
        wbs_adr_i = adr;  wbs_dat_i = dat;
        @(negedge wb_clk_i);
        wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
    endtask

    task automatic wb_read(input logic [31:0] adr, output logic [31:0] dat);
        if (wbs_ack_o) @(negedge wb_clk_i);
        wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = 1'b0;
        wbs_adr_i = adr;
        @(negedge wb_clk_i);
        dat = wbs_dat_o;
        wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0;
        @(negedge wb_clk_i);
    endtask

    // Called in the first DRIVE cycle; records stim_o per busy cycle.
    task automatic monitor_run(output int cycles, output int irqs);
        cycles = 0;
        irqs   = 0;
        while (busy_o && cycles < 256) begin
            stim_log[cycles] = stim_o;
            if (irq_o) irqs++;
            cycles++;
            @(negedge wb_clk_i);
        end
        for (int i = 0; i < 3; i++) begin
            if (irq_o) irqs++;
            @(negedge wb_clk_i);
        end
    endtask

    task automatic test_reset;
        logic [31:0] d;
        repeat (2) @(negedge wb_clk_i);
        checks++;
        if ({stim_o, busy_o, irq_o, wbs_ack_o, wbs_dat_o} !== 39'd0) begin
            $display("FAIL reset_outputs: got stim=%h busy=%b irq=%b ack=%b dat=%h, want all 0",
                     stim_o, busy_o, irq_o, wbs_ack_o, wbs_dat_o);
            errors++;
        end
        wb_rst_ni = 1'b1;
        @(negedge wb_clk_i);
        for (int a = 0; a < 4; a++) begin
            wb_read(32'(a * 4), d);
            checks++;
            if (d !== 32'd0) begin
                $display("FAIL reset_reg%0d: got %h, want 0", a * 4, d);
                errors++;
            end
        end
        $display("test_reset done");
    endtask

    task automatic test_wishbone;
        logic [31:0] d;
        wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = 32'h4;
        @(negedge wb_clk_i);
        checks++;
        if (wbs_ack_o !== 1'b1) begin
            $display("FAIL ack_first: got %b, want 1", wbs_ack_o);
            errors++;
        end
        @(negedge wb_clk_i);
        checks++;
        if (wbs_ack_o !== 1'b0 || wbs_dat_o !== 32'd0) begin
            $display("FAIL ack_single: got ack=%b dat=%h, want ack=0 dat=0", wbs_ack_o, wbs_dat_o);
            errors++;
        end
        wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0;
        @(negedge wb_clk_i);
        wb_write(32'h0, 32'h0000_0350);
        checks++;
        if (busy_o !== 1'b0) begin
            $display("FAIL ctrl_nostart_busy: got %b, want 0", busy_o);
            errors++;
        end
        wb_read(32'h0, d);
        checks++;
        if (d !== 32'h0000_0350) begin
            $display("FAIL ctrl_readback: got %h, want 00000350", d);
            errors++;
        end
        $display("test_wishbone done");
    endtask

    task automatic test_and2;
        int cyc, irqs;
        logic [31:0] d;
        cur_sel = 4'd0; resp_mode = 0;
        wb_write(32'h0, 32'h0000_0101);
        monitor_run(cyc, irqs);
        checks++;
        if (cyc != 16 || irqs != 1) begin
            $display("FAIL and2_timing: got cycles=%0d irqs=%0d, want 16 and 1", cyc, irqs);
            errors++;
        end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (stim_log[i] !== 4'(i / 4)) begin
                $display("FAIL and2_stim%0d: got %h, want %h", i, stim_log[i], 4'(i / 4));
                errors++;
            end
        end
        wb_read(32'h4, d);
        checks++;
        if (d !== 32'h2) begin
            $display("FAIL and2_status: got %h, want 2", d);
            errors++;
        end
        wb_read(32'h8, d);
        checks++;
        if (d !== 32'h0) begin
            $display("FAIL and2_errcnt: got %0d, want 0", d);
            errors++;
        end
        $display("test_and2 cycles=%0d irqs=%0d", cyc, irqs);
    endtask

    task automatic test_aoi22_stuck;
        int cyc, irqs;
        logic [31:0] d;
        cur_sel = 4'd2; resp_mode = 1;
        wb_write(32'h0, 32'h0000_0121);
        monitor_run(cyc, irqs);
        checks++;
        if (cyc != 64 || irqs != 1 || stim_log[63] !== 4'hF) begin
            $display("FAIL aoi22_timing: got cycles=%0d irqs=%0d last=%h, want 64 1 f",
                     cyc, irqs, stim_log[63]);
            errors++;
        end
        // ~(AB|CD) is 1 on 16 - (4 + 4 - 1) = 9 vectors
        wb_read(32'h8, d);
        checks++;
        if (d !== 32'd9) begin
            $display("FAIL aoi22_errcnt: got %0d, want 9", d);
            errors++;
        end
        wb_read(32'hC, d);
        checks++;
        if (d !== 32'h100) begin
            $display("FAIL aoi22_firstfail: got %h, want 100", d);
            errors++;
        end
        wb_read(32'h4, d);
        checks++;
        if (d !== 32'h6) begin
            $display("FAIL aoi22_status: got %h, want 6", d);
            errors++;
        end
        $display("test_aoi22_stuck cycles=%0d", cyc);
    endtask

    task automatic test_inv_passes;
        int cyc, irqs;
        logic [31:0] d;
        cur_sel = 4'd4; resp_mode = 2;
        wb_write(32'h0, 32'h0000_0341);
        monitor_run(cyc, irqs);
        checks++;
        if (cyc != 24 || irqs != 1) begin
            $display("FAIL inv_timing: got cycles=%0d irqs=%0d, want 24 and 1", cyc, irqs);
            errors++;
        end
        for (int i = 0; i < 24; i++) begin
            checks++;
            if (stim_log[i] !== 4'((i / 4) % 2)) begin
                $display("FAIL inv_stim%0d: got %h, want %h", i, stim_log[i], 4'((i / 4) % 2));
                errors++;
            end
        end
        wb_read(32'h8, d);
        checks++;
        if (d !== 32'd6) begin
            $display("FAIL inv_errcnt: got %0d, want 6", d);
            errors++;
        end
        $display("test_inv_passes cycles=%0d", cyc);
    endtask

    task automatic test_bad_sel;
        int cyc, irqs;
        logic [31:0] d;
        wb_write(32'h0, 32'h0000_01C1);
        monitor_run(cyc, irqs);
        checks++;
        if (cyc != 0 || irqs != 1) begin
            $display("FAIL badsel_run: got busy_cycles=%0d irqs=%0d, want 0 and 1", cyc, irqs);
            errors++;
        end
        wb_read(32'h4, d);
        checks++;
        if (d !== 32'hA) begin
            $display("FAIL badsel_status: got %h, want a", d);
            errors++;
        end
        wb_read(32'h8, d);
        checks++;
        if (d !== 32'd0) begin
            $display("FAIL badsel_errcnt_cleared: got %0d, want 0", d);
            errors++;
        end
        $display("test_bad_sel done");
    endtask

    task automatic test_abort;
        int w, irqs;
        logic [31:0] d;
        cur_sel = 4'd7; resp_mode = 1;
        wb_write(32'h0, 32'h0000_0171);
        w = 0;
        while (stim_o !== 4'd5 && w < 200) begin
            @(negedge wb_clk_i);
            w++;
        end
        checks++;
        if (stim_o !== 4'd5) begin
            $display("FAIL abort_reach_vec5: got stim=%h, want 5", stim_o);
            errors++;
        end
        wb_write(32'h0, 32'h0000_0243);
        checks++;
        if (stim_o !== 4'd0 || busy_o !== 1'b0) begin
            $display("FAIL abort_stop: got stim=%h busy=%b, want 0 0", stim_o, busy_o);
            errors++;
        end
        irqs = 0;
        for (int i = 0; i < 4; i++) begin
            if (irq_o) irqs++;
            @(negedge wb_clk_i);
        end
        checks++;
        if (irqs != 0) begin
            $display("FAIL abort_irq: got %0d pulses, want 0", irqs);
            errors++;
        end
        wb_read(32'h4, d);
        checks++;
        if (d !== 32'h4) begin
            $display("FAIL abort_status: got %h, want 4", d);
            errors++;
        end
        wb_read(32'h8, d);
        checks++;
        if (d !== 32'd5) begin
            $display("FAIL abort_errcnt: got %0d, want 5", d);
            errors++;
        end
        wb_read(32'h0, d);
        checks++;
        if (d !== 32'h0000_0170) begin
            $display("FAIL abort_ctrl_kept: got %h, want 00000170", d);
            errors++;
        end
        $display("test_abort done");
    endtask

    task automatic test_reset_midrun;
        int cyc, irqs;
        logic [31:0] d;
        cur_sel = 4'd0; resp_mode = 0;
        wb_write(32'h0, 32'h0000_0101);
        repeat (6) @(negedge wb_clk_i);
        #2 wb_rst_ni = 1'b0;
        #1;
        checks++;
        if ({stim_o, busy_o, irq_o, wbs_ack_o, wbs_dat_o} !== 39'd0) begin
            $display("FAIL midrun_reset_async: got stim=%h busy=%b irq=%b ack=%b, want all 0",
                     stim_o, busy_o, irq_o, wbs_ack_o);
            errors++;
        end
        repeat (2) @(negedge wb_clk_i);
        wb_rst_ni = 1'b1;
        @(negedge wb_clk_i);
        wb_read(32'h0, d);
        checks++;
        if (d !== 32'h0) begin
            $display("FAIL midrun_ctrl_cleared: got %h, want 0", d);
            errors++;
        end
        wb_write(32'h0, 32'h0000_0201);
        monitor_run(cyc, irqs);
        checks++;
        if (cyc != 32 || irqs != 1) begin
            $display("FAIL midrun_restart: got cycles=%0d irqs=%0d, want 32 and 1", cyc, irqs);
            errors++;
        end
        wb_read(32'h4, d);
        checks++;
        if (d !== 32'h2) begin
            $display("FAIL midrun_status: got %h, want 2", d);
            errors++;
        end
        $display("test_reset_midrun cycles=%0d", cyc);
    endtask

    initial begin
        wb_rst_ni = 1'b0;
        wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
        wbs_adr_i = 32'd0; wbs_dat_i = 32'd0;
        cur_sel = 4'd0; resp_mode = 0;
        test_reset;
        test_wishbone;
        test_and2;
        test_aoi22_stuck;
        test_inv_passes;
        test_bad_sel;
        test_abort;
        test_reset_midrun;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
